pipelined_cla_adder: RTL and testbench



---
 rtl/pipelined_cla_adder.sv | 114 +++++++++++
 tb/tb_pipelined_cla_adder.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor: one GROUP-bit lookahead group is resolved per stage,
// followed by an output register, under a valid/ready handshake with full backpressure.
module pipelined_cla_adder #(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             Cout,
  output logic             ovf
);

  localparam int NSTAGE = WIDTH / GROUP;

  if ((WIDTH % GROUP) != 0 || WIDTH < GROUP) begin : g_param_check
    $error("pipelined_cla_adder: WIDTH must be a non-zero multiple of GROUP");
  end

  // Carries c[0..GROUP] of one group, each a flat sum of products of g, p and c0 (no ripple).
  function automatic logic [GROUP:0] lookahead(input logic [GROUP-1:0] g,
                                               input logic [GROUP-1:0] p,
                                               input logic             c0);
    logic [GROUP:0] c;
    logic           term;
    c    = '0;
    c[0] = c0;
    for (int i = 0; i < GROUP; i++) begin
      term = c0;
      for (int m = 0; m <= i; m++) term = term & p[m];
      c[i+1] = term;
      for (int j = 0; j <= i; j++) begin
        term = g[j];
        for (int m = j + 1; m <= i; m++) term = term & p[m];
        c[i+1] = c[i+1] | term;
      end
    end
    return c;
  endfunction

  // Stage k: effective operands, result bits below group k resolved, carry into group k.
  logic [NSTAGE-1:0]             stg_vld;
  logic [WIDTH-1:0]              stg_a   [NSTAGE];
  logic [WIDTH-1:0]              stg_b   [NSTAGE];
  logic [WIDTH-1:0]              stg_res [NSTAGE];
  logic [NSTAGE-1:0]             stg_c;

  logic [NSTAGE-1:0][GROUP-1:0]  grp_g;
  logic [NSTAGE-1:0][GROUP-1:0]  grp_p;
  logic [NSTAGE-1:0][GROUP:0]    grp_c;
  logic [WIDTH-1:0]              nxt_res [NSTAGE];

  logic stall;

  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;

  always_comb begin
    for (int k = 0; k < NSTAGE; k++) begin
      grp_g[k]   = stg_a[k][GROUP*k +: GROUP] & stg_b[k][GROUP*k +: GROUP];
      grp_p[k]   = stg_a[k][GROUP*k +: GROUP] ^ stg_b[k][GROUP*k +: GROUP];
      grp_c[k]   = lookahead(grp_g[k], grp_p[k], stg_c[k]);
      // NOTE: default the whole word first so no path leaves nxt_res unassigned (no latch).
      nxt_res[k] = stg_res[k];
      nxt_res[k][GROUP*k +: GROUP] = grp_p[k] ^ grp_c[k][GROUP-1:0];
    end
  end

  // Control and output registers: these carry reset so no stale beat survives it.
  always_ff @(posedge clk) begin
    if (rst) begin
      stg_vld   <= '0;
      out_valid <= 1'b0;
      sum       <= '0;
      Cout      <= 1'b0;
      ovf       <= 1'b0;
    end else if (!stall) begin
      // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
      stg_vld[0] <= in_valid;
      for (int k = 1; k < NSTAGE; k++) stg_vld[k] <= stg_vld[k-1];
      out_valid <= stg_vld[NSTAGE-1];
      if (stg_vld[NSTAGE-1]) begin
        sum  <= nxt_res[NSTAGE-1];
        Cout <= grp_c[NSTAGE-1][GROUP];
        ovf  <= grp_c[NSTAGE-1][GROUP] ^ grp_c[NSTAGE-1][GROUP-1];
      end
    end
  end

  // NOTE: the datapath stages are not reset; their contents only matter when the valid bit is set.
  always_ff @(posedge clk) begin
    if (!stall) begin
      stg_a[0]   <= A;
      stg_b[0]   <= B ^ {WIDTH{sub}};
      stg_c[0]   <= Cin ^ sub;
      stg_res[0] <= '0;
      for (int k = 1; k < NSTAGE; k++) begin
        stg_a[k]   <= stg_a[k-1];
        stg_b[k]   <= stg_b[k-1];
        stg_res[k] <= nxt_res[k-1];
        stg_c[k]   <= grp_c[k-1][GROUP];
      end
    end
  end

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Scoreboard bench for pipelined_cla_adder: the driver queues expected results on accept,
// a negedge monitor compares every presented result against the head of the queue.
module tb_pipelined_cla_adder;

  localparam int W  = 16;
  localparam int G  = 4;
  localparam int NS = W / G;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         Cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         Cout;
  logic         ovf;

  pipelined_cla_adder #(.WIDTH(W), .GROUP(G)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .Cin       (Cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .Cout      (Cout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    bit           lat;
    int           acc;
  } exp_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } vec_t;

  exp_t sb[$];
  int   total     = 0;
  int   bad       = 0;
  int   cyc       = 0;
  int   rdy_mode  = 0;
  int   rdy_hold  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain wide addition on the effective operands, overflow from the sign rule.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin, input logic s);
    exp_t         e;
    logic [W-1:0] be;
    logic         ce;
    logic [W:0]   f;
    be     = s ? ~b : b;
    ce     = s ? ~cin : cin;
    f      = {1'b0, a} + {1'b0, be} + {{W{1'b0}}, ce};
    e.sum  = f[W-1:0];
    e.cout = f[W];
    e.ovf  = (a[W-1] == be[W-1]) && (f[W-1] != a[W-1]);
    e.lat  = 1'b0;
    e.acc  = 0;
    return e;
  endfunction

  // Holds the beat until in_ready is seen, then queues its expected result.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                      input logic s, input exp_t e);
    A = a; B = b; Cin = c; sub = s; in_valid = 1'b1;
    for (int w = 0; w < 500; w++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    if (!in_ready) begin
      total++; bad++;
      $display("FAIL accept_timeout: in_ready stayed low, required high");
    end else begin
      e.acc = cyc + 1;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int w = 0; w < 2000 && sb.size() != 0; w++) @(posedge clk);
    if (sb.size() != 0) begin
      total++; bad++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", sb.size());
    end
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (out_valid) begin
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_output: got sum=%0h, required no result", sum);
      end else begin
        check("sum", 32'(sum), 32'(sb[0].sum));
        check("cout", 32'(Cout), 32'(sb[0].cout));
        check("ovf", 32'(ovf), 32'(sb[0].ovf));
        if (!out_ready) begin
          check("in_ready_stalled", 32'(in_ready), 32'd0);
        end else begin
          if (sb[0].lat) check("latency", 32'(cyc - sb[0].acc), 32'(NS));
          void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (rdy_mode == 0) out_ready = 1'b1;
      else if (rdy_hold > 0) begin
        out_ready = 1'b0;
        rdy_hold--;
      end else out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t         dir[8];
    exp_t         e;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rc;
    logic         rs;

    dir[0] = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};
    dir[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    dir[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    dir[3] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    dir[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    dir[5] = '{16'h0010, 16'h0003, 1'b1, 1'b1, 16'h000C, 1'b1, 1'b0};
    dir[6] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    dir[7] = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};

    rst = 1'b1; in_valid = 1'b0; A = '0; B = '0; Cin = 1'b0; sub = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_sum", 32'(sum), 32'd0);
    check("reset_cout", 32'(Cout), 32'd0);
    check("reset_ovf", 32'(ovf), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    // Hand-computed vectors, issued back to back.
    for (int i = 0; i < 8; i++) begin
      e.sum = dir[i].sum; e.cout = dir[i].cout; e.ovf = dir[i].ovf; e.lat = 1'b1; e.acc = 0;
      send(dir[i].a, dir[i].b, dir[i].cin, dir[i].sub, e);
    end
    drain();

    // Streaming at full rate; no stalls, so every beat must still show NS-cycle latency.
    for (int i = 0; i < 200; i++) begin
      ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom); rs = 1'($urandom);
      e = model(ra, rb, rc, rs);
      e.lat = 1'b1;
      send(ra, rb, rc, rs, e);
    end
    drain();

    // Backpressure: out_ready low for 5 cycles, then random.
    rdy_hold = 5;
    rdy_mode = 1;
    for (int i = 0; i < 60; i++) begin
      ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom); rs = 1'($urandom);
      send(ra, rb, rc, rs, model(ra, rb, rc, rs));
    end
    drain();
    rdy_mode = 0;
    repeat (2) @(posedge clk);
    #1;

    // Reset mid-flight: beats at t1 and t1+1 are dropped, the third collides with reset.
    A = 16'h1111; B = 16'h2222; Cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    A = 16'h3333; B = 16'h4444;
    @(posedge clk); #1;
    A = 16'h5555; B = 16'h6666; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("midreset_out_valid", 32'(out_valid), 32'd0);
    check("midreset_sum", 32'(sum), 32'd0);
    check("midreset_cout", 32'(Cout), 32'd0);
    check("midreset_ovf", 32'(ovf), 32'd0);
    check("midreset_in_ready", 32'(in_ready), 32'd1);
    repeat (10) @(posedge clk);
    #1;
    e.sum = 16'h2345; e.cout = 1'b0; e.ovf = 1'b0; e.lat = 1'b1; e.acc = 0;
    send(16'h1234, 16'h1111, 1'b0, 1'b0, e);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
